fifo_sync_param: RTL and testbench

Parametrised single-clock FIFO, the next generation of the board-level byte FIFO. Generalised width and depth, exact full/empty over all `depth` entries, simultaneous read and write, programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush and a selectable first-word-fall-through (FWFT) read mode. Sits between debounced/edge-detected push sources and the downstream consumer; push-button conditioning stays outside this block.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_sync_param_if.sv | 36 +++
 rtl/fifo_dpram.sv | 29 ++
 rtl/fifo_sync_param.sv | 121 ++++++++++++
 tb/tb_fifo_sync_param.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: default geometry,
// read-mode selectors and the pointer-width helper.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 16;

    // Read-mode selectors for the fwft parameter
    localparam int FIFO_MODE_STD  = 0;
    localparam int FIFO_MODE_FWFT = 1;

    // Number of address bits needed to index n entries (ceil(log2(n)))
    function automatic int fifo_ptr_w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
// The master side pushes/pops and observes status; the slave side is the FIFO.
interface fifo_sync_param_if
    import fifo_pkg::*;
#(
    parameter int width = FIFO_DEF_WIDTH,
    parameter int depth = FIFO_DEF_DEPTH
);
    localparam int cw = fifo_ptr_w(depth) + 1;

    logic             clr;
    logic             wr_en;
    logic [width-1:0] wr_data;
    logic             rd_en;
    logic [width-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [cw-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output clr, wr_en, wr_data, rd_en,
        input  rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  clr, wr_en, wr_data, rd_en,
        output rd_data, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous
// read port, depth x width.
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int width = FIFO_DEF_WIDTH,
    parameter int depth = FIFO_DEF_DEPTH
)(
    input  logic                         clk,
    input  logic                         we,
    input  logic [fifo_ptr_w(depth)-1:0] waddr,
    input  logic [width-1:0]             wdata,
    input  logic [fifo_ptr_w(depth)-1:0] raddr,
    output logic [width-1:0]             rdata
);

    logic [width-1:0] mem [depth];

    // Store the incoming word at the write address
    // NOTE: storage has no reset on purpose -- a reset would force flops
    // instead of RAM, and the pointers already mark every entry invalid.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every flop samples pre-edge values.
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO: pointers, occupancy count, threshold flags,
// sticky error flags, synchronous flush and selectable FWFT read mode.
module fifo_sync_param
    import fifo_pkg::*;
#(
    parameter int width     = FIFO_DEF_WIDTH,
    parameter int depth     = FIFO_DEF_DEPTH,
    parameter int afull_th  = 14,
    parameter int aempty_th = 2,
    parameter int fwft      = FIFO_MODE_STD
)(
    input  logic             clk,
    input  logic             rst,
    fifo_sync_param_if.slave bus
);

    localparam int aw = fifo_ptr_w(depth);

    localparam logic [aw-1:0] ptr_one    = aw'(1);
    localparam logic [aw:0]   cnt_one    = (aw+1)'(1);
    localparam logic [aw:0]   cnt_full   = (aw+1)'(depth);
    localparam logic [aw:0]   afull_lim  = (aw+1)'(afull_th);
    localparam logic [aw:0]   aempty_lim = (aw+1)'(aempty_th);

    logic [aw-1:0]    wr_ptr_q, rd_ptr_q;
    logic [aw:0]      count_q, count_nxt;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic             ovf_q, unf_q;
    logic             wr_acc, rd_acc;
    logic [width-1:0] mem_rdata;

    // Acceptance uses the registered flags only, so no enable reaches an output
    assign wr_acc = bus.wr_en && !full_q  && !bus.clr;
    assign rd_acc = bus.rd_en && !empty_q && !bus.clr;

    // Next occupancy from the accepted operations; flush wins
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        count_nxt = count_q;
        if (bus.clr) begin
            count_nxt = '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   count_nxt = count_q + cnt_one;
                2'b01:   count_nxt = count_q - cnt_one;
                default: count_nxt = count_q;
            endcase
        end
    end

    // Pointers, count, flags and sticky errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (bus.clr) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr_q <= wr_ptr_q + ptr_one;
                if (rd_acc) rd_ptr_q <= rd_ptr_q + ptr_one;
                if (bus.wr_en && full_q)  ovf_q <= 1'b1;
                if (bus.rd_en && empty_q) unf_q <= 1'b1;
            end
            count_q  <= count_nxt;
            full_q   <= (count_nxt == cnt_full);
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= afull_lim);
            aempty_q <= (count_nxt <= aempty_lim);
        end
    end

    fifo_dpram #(
        .width (width),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    generate
        if (fwft == FIFO_MODE_FWFT) begin : g_fwft
            // Head entry presented directly; forced to zero while empty
            assign bus.rd_data = empty_q ? '0 : mem_rdata;
        end else begin : g_std
            logic [width-1:0] rd_q;

            // Capture the head entry on the edge that accepts a read
            always_ff @(posedge clk or posedge rst) begin
                if (rst)          rd_q <= '0;
                else if (bus.clr) rd_q <= '0;
                else if (rd_acc)  rd_q <= mem_rdata;
            end

            assign bus.rd_data = rd_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: one registered-read instance and
// one FWFT instance, a scoreboard queue of expected read data and a small
// occupancy/flag model.
module tb_fifo_sync_param;
    import fifo_pkg::*;

    localparam int W = 8;
    localparam int D = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_sync_param_if #(.width(W), .depth(D)) if_std ();
    fifo_sync_param_if #(.width(W), .depth(D)) if_ff ();

    fifo_sync_param #(
        .width(W), .depth(D), .afull_th(14), .aempty_th(2), .fwft(FIFO_MODE_STD)
    ) dut_std (
        .clk (clk),
        .rst (rst),
        .bus (if_std.slave)
    );

    fifo_sync_param #(
        .width(W), .depth(D), .afull_th(14), .aempty_th(2), .fwft(FIFO_MODE_FWFT)
    ) dut_ff (
        .clk (clk),
        .rst (rst),
        .bus (if_ff.slave)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [W-1:0] sb_q [$];
    int           m_count;
    logic         m_ovf, m_unf;
    logic [W-1:0] m_rd;

    // {count, full, empty, almost_full, almost_empty, overflow, underflow}
    function automatic logic [10:0] exp_status(input int c, input logic o, input logic u);
        return {5'(c), (c == 16), (c == 0), (c >= 14), (c <= 2), o, u};
    endfunction

    function automatic logic [10:0] std_status();
        return {if_std.count, if_std.full, if_std.empty, if_std.almost_full,
                if_std.almost_empty, if_std.overflow, if_std.underflow};
    endfunction

    function automatic logic [10:0] ff_status();
        return {if_ff.count, if_ff.full, if_ff.empty, if_ff.almost_full,
                if_ff.almost_empty, if_ff.overflow, if_ff.underflow};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_rd    = '0;
    endtask

    // One clock on the registered-read instance, with model update and checks
    task automatic cycle_std(input logic wr, input logic [W-1:0] d, input logic rd, input string tag);
        logic wa, ra;
        wa = wr && (m_count < D);
        ra = rd && (m_count > 0);
        if (wr && m_count == D) m_ovf = 1'b1;
        if (rd && m_count == 0) m_unf = 1'b1;
        if (ra) m_rd = sb_q.pop_front();
        if (wa) sb_q.push_back(d);
        m_count = m_count + int'(wa) - int'(ra);

        if_std.wr_en   = wr;
        if_std.wr_data = d;
        if_std.rd_en   = rd;
        tick();
        if_std.wr_en = 1'b0;
        if_std.rd_en = 1'b0;

        total_cnt++;
        if (std_status() !== exp_status(m_count, m_ovf, m_unf))
            $display("FAIL %s status: got %b want %b", tag, std_status(), exp_status(m_count, m_ovf, m_unf));
        else pass_cnt++;
        total_cnt++;
        if (if_std.rd_data !== m_rd)
            $display("FAIL %s rd_data: got %h want %h", tag, if_std.rd_data, m_rd);
        else pass_cnt++;
    endtask

    // Flush the registered-read instance with push/pop also requested
    task automatic clr_std(input logic [W-1:0] d, input string tag);
        if_std.clr     = 1'b1;
        if_std.wr_en   = 1'b1;
        if_std.rd_en   = 1'b1;
        if_std.wr_data = d;
        tick();
        if_std.clr   = 1'b0;
        if_std.wr_en = 1'b0;
        if_std.rd_en = 1'b0;
        model_reset();
        total_cnt++;
        if (std_status() !== exp_status(0, 1'b0, 1'b0))
            $display("FAIL %s status: got %b want %b", tag, std_status(), exp_status(0, 1'b0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (if_std.rd_data !== '0)
            $display("FAIL %s rd_data: got %h want 00", tag, if_std.rd_data);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_std.clr = 1'b0; if_std.wr_en = 1'b0; if_std.rd_en = 1'b0; if_std.wr_data = '0;
        if_ff.clr  = 1'b0; if_ff.wr_en  = 1'b0; if_ff.rd_en  = 1'b0; if_ff.wr_data  = '0;
        model_reset();
        tick();
        tick();
        total_cnt++;
        if (std_status() !== exp_status(0, 1'b0, 1'b0))
            $display("FAIL reset_std status: got %b want %b", std_status(), exp_status(0, 1'b0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (if_std.rd_data !== '0)
            $display("FAIL reset_std rd_data: got %h want 00", if_std.rd_data);
        else pass_cnt++;
        total_cnt++;
        if (ff_status() !== exp_status(0, 1'b0, 1'b0))
            $display("FAIL reset_ff status: got %b want %b", ff_status(), exp_status(0, 1'b0, 1'b0));
        else pass_cnt++;
        rst = 1'b0;

        // Reset asserted between edges must clear state without a clock edge
        for (int i = 0; i < 3; i++) cycle_std(1'b1, W'(8'h90 + i), 1'b0, "pre_rst");
        cycle_std(1'b0, '0, 1'b1, "pre_rst_rd");
        #2 rst = 1'b1;
        #1;
        model_reset();
        total_cnt++;
        if (std_status() !== exp_status(0, 1'b0, 1'b0))
            $display("FAIL async_rst status: got %b want %b", std_status(), exp_status(0, 1'b0, 1'b0));
        else pass_cnt++;
        total_cnt++;
        if (if_std.rd_data !== '0)
            $display("FAIL async_rst rd_data: got %h want 00", if_std.rd_data);
        else pass_cnt++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) cycle_std(1'b1, W'(8'h10 + i), 1'b0, "flush_wr");
        clr_std(8'h77, "flush_clr");
        // The word offered during the flush must not have been stored
        cycle_std(1'b1, 8'h11, 1'b0, "flush_post_wr");
        cycle_std(1'b0, '0, 1'b1, "flush_post_rd");
        total_cnt++;
        if (if_std.rd_data !== 8'h11)
            $display("FAIL flush_word: got %h want 11", if_std.rd_data);
        else pass_cnt++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            cycle_std(1'b1, W'(i), 1'b0, "fill");
            if (i == 12) begin
                total_cnt++;
                if (if_std.almost_full !== 1'b0)
                    $display("FAIL afull_13: got %b want 0", if_std.almost_full);
                else pass_cnt++;
            end
            if (i == 13) begin
                total_cnt++;
                if ({if_std.almost_full, if_std.count} !== {1'b1, 5'd14})
                    $display("FAIL afull_14: got af=%b cnt=%0d want af=1 cnt=14", if_std.almost_full, if_std.count);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if ({if_std.full, if_std.count} !== {1'b1, 5'd16})
            $display("FAIL full_16: got full=%b cnt=%0d want full=1 cnt=16", if_std.full, if_std.count);
        else pass_cnt++;
        cycle_std(1'b1, 8'hAA, 1'b0, "ovf_wr");
        total_cnt++;
        if (if_std.overflow !== 1'b1)
            $display("FAIL overflow_set: got %b want 1", if_std.overflow);
        else pass_cnt++;
        for (int i = 0; i < 16; i++) cycle_std(1'b0, '0, 1'b1, "drain");
        total_cnt++;
        if (if_std.rd_data !== 8'h0F)
            $display("FAIL drain_last: got %h want 0f", if_std.rd_data);
        else pass_cnt++;
        clr_std('0, "fd_clr");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) cycle_std(1'b1, W'(8'h20 + i), 1'b0, "wrap_wr1");
        for (int i = 0; i < 10; i++) cycle_std(1'b0, '0, 1'b1, "wrap_rd1");
        for (int i = 0; i < 12; i++) cycle_std(1'b1, W'(8'h40 + i), 1'b0, "wrap_wr2");
        for (int i = 0; i < 12; i++) cycle_std(1'b0, '0, 1'b1, "wrap_rd2");
        total_cnt++;
        if (if_std.count !== 5'd0)
            $display("FAIL wrap_count: got %0d want 0", if_std.count);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 7; i++) cycle_std(1'b1, W'(8'h50 + i), 1'b0, "sim_pre");
        for (int i = 0; i < 20; i++) cycle_std(1'b1, W'(8'h60 + i), 1'b1, "sim_rw");
        total_cnt++;
        if (if_std.count !== 5'd7)
            $display("FAIL sim_count7: got %0d want 7", if_std.count);
        else pass_cnt++;
        for (int i = 0; i < 9; i++) cycle_std(1'b1, W'(8'h80 + i), 1'b0, "sim_fill");
        cycle_std(1'b1, 8'hBB, 1'b1, "sim_full_rw");
        total_cnt++;
        if ({if_std.count, if_std.overflow} !== {5'd15, 1'b1})
            $display("FAIL sim_full: got cnt=%0d ovf=%b want cnt=15 ovf=1", if_std.count, if_std.overflow);
        else pass_cnt++;
        for (int i = 0; i < 15; i++) cycle_std(1'b0, '0, 1'b1, "sim_drain");
        clr_std('0, "sim_clr");
    endtask

    task automatic test_underflow();
        cycle_std(1'b1, 8'h3C, 1'b0, "unf_wr");
        cycle_std(1'b0, '0, 1'b1, "unf_rd");
        cycle_std(1'b0, '0, 1'b1, "unf_empty_rd");
        total_cnt++;
        if ({if_std.underflow, if_std.count, if_std.rd_data} !== {1'b1, 5'd0, 8'h3C})
            $display("FAIL underflow: got unf=%b cnt=%0d rd=%h want unf=1 cnt=0 rd=3c",
                     if_std.underflow, if_std.count, if_std.rd_data);
        else pass_cnt++;
        for (int i = 0; i < 3; i++) cycle_std(1'b0, '0, 1'b0, "unf_idle");
        cycle_std(1'b1, 8'h3D, 1'b0, "unf_wr2");
        cycle_std(1'b0, '0, 1'b1, "unf_rd2");
        total_cnt++;
        if (if_std.underflow !== 1'b1)
            $display("FAIL unf_sticky: got %b want 1", if_std.underflow);
        else pass_cnt++;
        clr_std('0, "unf_clr");
    endtask

    task automatic test_fwft();
        logic [W-1:0] ff_q [$];
        if_ff.wr_en   = 1'b1;
        if_ff.wr_data = 8'h5A;
        tick();
        if_ff.wr_en = 1'b0;
        total_cnt++;
        if ({if_ff.rd_data, if_ff.empty} !== {8'h5A, 1'b0})
            $display("FAIL fwft_first: got rd=%h empty=%b want rd=5a empty=0", if_ff.rd_data, if_ff.empty);
        else pass_cnt++;
        if_ff.rd_en = 1'b1;
        tick();
        if_ff.rd_en = 1'b0;
        total_cnt++;
        if (ff_status() !== exp_status(0, 1'b0, 1'b0))
            $display("FAIL fwft_pop: got %b want %b", ff_status(), exp_status(0, 1'b0, 1'b0));
        else pass_cnt++;

        // Burst of words, then pop while checking the presented head
        for (int i = 0; i < 4; i++) begin
            if_ff.wr_en   = 1'b1;
            if_ff.wr_data = W'(8'hA1 + i);
            ff_q.push_back(W'(8'hA1 + i));
            tick();
        end
        if_ff.wr_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (if_ff.rd_data !== ff_q[0])
                $display("FAIL fwft_head%0d: got %h want %h", i, if_ff.rd_data, ff_q[0]);
            else pass_cnt++;
            void'(ff_q.pop_front());
            if_ff.rd_en = 1'b1;
            tick();
            if_ff.rd_en = 1'b0;
        end
        total_cnt++;
        if (if_ff.empty !== 1'b1)
            $display("FAIL fwft_drained: got empty=%b want 1", if_ff.empty);
        else pass_cnt++;

        // Same write on the registered-read instance: data only after rd_en
        cycle_std(1'b1, 8'h5A, 1'b0, "std_5a_wr");
        cycle_std(1'b0, '0, 1'b1, "std_5a_rd");
        total_cnt++;
        if (if_std.rd_data !== 8'h5A)
            $display("FAIL std_5a: got %h want 5a", if_std.rd_data);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_flush();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_underflow();
        test_fwft();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
